bwd_ready_fifo: RTL and testbench



---
 rtl/bwd_ready_fifo_if.sv | 8 +
 rtl/bwd_ready_fifo.sv | 55 +++++
 tb/tb_bwd_ready_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bwd_ready_fifo_if.sv
// bwd_ready_fifo_if: ready/valid link; master drives data/valid, slave drives ready.
interface bwd_ready_fifo_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/bwd_ready_fifo.sv
// bwd_ready_fifo: DEPTH-entry ready/valid buffer whose upstream ready depends only on registered occupancy.
// Optional BWD_READY_FIFO_BYPASS_EN passes a beat straight through when empty and downstream is ready.
module bwd_ready_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bwd_ready_fifo_if.slave        up,
    bwd_ready_fifo_if.master       dn,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty, push, pop, wr, rd;
    always_comb begin
        empty    = level_q == '0;
        // Only level_q and rst feed ready, so out_ready never reaches the producer combinationally.
        up.ready = !rst && level_q != (AW+1)'(DEPTH);
        push     = up.valid && up.ready;
`ifdef BWD_READY_FIFO_BYPASS_EN
        dn.valid = !rst && (!empty || push);
        dn.data  = !dn.valid ? '0 : empty ? up.data : mem[rd_ptr_q];
        pop      = dn.valid && dn.ready;
        wr       = push && !(empty && dn.ready);
        rd       = pop && !empty;
`else
        dn.valid = !rst && !empty;
        dn.data  = dn.valid ? mem[rd_ptr_q] : '0;
        pop      = dn.valid && dn.ready;
        wr       = push;
        rd       = pop;
`endif
        level_d  = level_q + (AW+1)'(wr) - (AW+1)'(rd);
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        level    = level_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= up.data;
    end
endmodule

// File: tb/tb_bwd_ready_fifo.sv
// tb_bwd_ready_fifo: queue-model checker for bwd_ready_fifo with directed and random traffic.
module tb_bwd_ready_fifo;
    localparam int W = 8;
    localparam int D = 4;
`ifdef BWD_READY_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(D):0] level;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    bwd_ready_fifo_if #(.DATA_WIDTH(W)) in_if ();
    bwd_ready_fifo_if #(.DATA_WIDTH(W)) out_if ();
    bwd_ready_fifo #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .up    (in_if.slave),
        .dn    (out_if.master),
        .level (level)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    logic [W-1:0] mq [$];
    int           m_n;
    bit           m_ir, m_byp, m_ov, m_pu, m_po;
    logic [W-1:0] m_od;
    always @(negedge clk) begin
        m_n  = mq.size();
        m_ir = !rst && m_n < D;
        m_byp = BYP && m_n == 0 && in_if.valid === 1'b1 && m_ir;
        m_ov = !rst && (m_n > 0 || m_byp);
        m_od = !m_ov ? '0 : (m_n > 0 ? mq[0] : in_if.data);
        chk("model_in_ready", 32'(in_if.ready), 32'(m_ir));
        chk("model_out_valid", 32'(out_if.valid), 32'(m_ov));
        chk("model_out_data", 32'(out_if.data), 32'(m_od));
        chk("model_level", 32'(level), 32'(m_n));
        if (rst) mq.delete();
        else begin
            m_pu = in_if.valid && m_ir;
            m_po = m_ov && out_if.ready;
            if (m_po && m_n > 0) void'(mq.pop_front());
            if (m_pu && !(m_po && m_n == 0)) mq.push_back(in_if.data);
        end
    end
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r);
        @(posedge clk); #1;
        rst = 1'b0;
        in_if.valid = v;
        in_if.data = d;
        out_if.ready = r;
    endtask
    initial begin
        logic [W-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [W-1:0] ex [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h00};
        bit acc;
        in_if.valid = 1'b1;
        in_if.data = 8'h77;
        out_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_if.ready), 0);
            chk("rst_out_valid", 32'(out_if.valid), 0);
            chk("rst_level", 32'(level), 0);
        end
        cyc(0, 0, 0);
        @(negedge clk);
        chk("rel_in_ready", 32'(in_if.ready), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, fill[i], 0);
            @(negedge clk);
            chk("fill_level", 32'(level), 32'(i));
        end
        cyc(1, 8'hAA, 0);
        @(negedge clk);
        chk("full_level", 32'(level), 4);
        chk("full_in_ready", 32'(in_if.ready), 0);
        cyc(1, 8'hAA, 0);
        @(negedge clk);
        chk("full_hold_ready", 32'(in_if.ready), 0);
        chk("full_head", 32'(out_if.data), 32'h11);
        cyc(1, 8'hAA, 1);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("drain_data", 32'(out_if.data), 32'(ex[j]));
            if (j == 1) chk("drain_ready_back", 32'(in_if.ready), 1);
            if (j < 5) begin
                @(posedge clk); #1;
                if (j == 1) in_if.valid = 1'b0;
            end
        end
        chk("drain_level", 32'(level), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, W'(i), 1);
            @(negedge clk);
            if (BYP) begin
                chk("stream_byp_data", 32'(out_if.data), 32'(i));
                chk("stream_byp_level", 32'(level), 0);
            end else if (i > 0) begin
                chk("stream_data", 32'(out_if.data), 32'(i - 1));
                chk("stream_level", 32'(level), 1);
            end
        end
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, W'($urandom), 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, W'($urandom), 0);
            @(negedge clk);
            chk("wrap_level_lo", 32'(level), 1);
            cyc(0, 0, 1);
            @(negedge clk);
            chk("wrap_level_hi", 32'(level), 2);
        end
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 8'hB1, 0);
        cyc(1, 8'hB2, 0);
        cyc(0, 0, 1);
        @(negedge clk);
        chk("bp_first", 32'(out_if.data), 32'hB1);
        chk("bp_level", 32'(level), 2);
        cyc(0, 0, 0);
        @(negedge clk);
        chk("bp_stall1", 32'(out_if.data), 32'hB2);
        chk("bp_stall1_valid", 32'(out_if.valid), 1);
        cyc(0, 0, 0);
        @(negedge clk);
        chk("bp_stall2", 32'(out_if.data), 32'hB2);
        cyc(0, 0, 1);
        @(negedge clk);
        chk("bp_release", 32'(out_if.data), 32'hB2);
        cyc(0, 0, 0);
        @(negedge clk);
        chk("bp_empty_valid", 32'(out_if.valid), 0);
        chk("bp_empty_data", 32'(out_if.data), 0);
        if (BYP) begin
            cyc(1, 8'h5A, 1);
            @(negedge clk);
            chk("byp_valid", 32'(out_if.valid), 1);
            chk("byp_data", 32'(out_if.data), 32'h5A);
            chk("byp_level", 32'(level), 0);
            cyc(0, 0, 0);
            @(negedge clk);
            chk("byp_after_level", 32'(level), 0);
        end
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = $urandom_range(99) == 0;
            if (!(in_if.valid && !acc)) begin
                in_if.valid = 1'($urandom_range(1));
                in_if.data = W'($urandom);
            end
            out_if.ready = $urandom_range(3) != 0;
            if (c % 500 > 250) out_if.ready = $urandom_range(3) == 0;
            @(negedge clk);
            acc = in_if.valid && in_if.ready;
        end
        cyc(0, 0, 1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
